// File: rtl/multicycle_control.sv
// Control FSM for a multicycle RV32I core: fetch/decode/execute/memory/write-back
// sequencing, ALU/immediate selection, bounded memory wait and a retired-instruction counter.
module multicycle_control #(
  parameter int ALUOP_W     = 4,
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [31:0]        instr,
  input  logic               instr_valid,
  output logic               instr_ready,
  input  logic               zero,
  input  logic               lt,
  input  logic               ltu,
  input  logic               mem_ready,
  input  logic               trap_clr,
  output logic               mem_req,
  output logic               regRW,
  output logic               ALUsrc,
  output logic               MRW,
  output logic               WB,
  output logic               PCsrc,
  output logic               pc_en,
  output logic [1:0]         immSel,
  output logic [ALUOP_W-1:0] ALUop,
  output logic               illegal,
  output logic [CNT_W-1:0]   retired
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WBACK, TRAP} state_t;
  typedef enum logic [2:0] {
    C_OPIMM, C_OP, C_LOAD, C_STORE, C_BRANCH, C_JAL, C_JALR, C_BAD
  } cls_t;

  state_t            state, next_state;
  logic [31:0]       ir;
  logic [WAIT_W-1:0] wait_cnt;
  cls_t              cls;
  logic [2:0]        funct3;
  logic              alt;
  logic              unused_ir;

  function automatic cls_t classify(input logic [6:0] opc, input logic [2:0] f3);
    case (opc)
      7'b0010011: classify = C_OPIMM;
      7'b0110011: classify = C_OP;
      7'b0000011: classify = C_LOAD;
      7'b0100011: classify = C_STORE;
      // funct3 010/011 have no branch meaning and are rejected at decode
      7'b1100011: classify = (f3 == 3'b010 || f3 == 3'b011) ? C_BAD : C_BRANCH;
      7'b1101111: classify = C_JAL;
      7'b1100111: classify = C_JALR;
      default:    classify = C_BAD;
    endcase
  endfunction

  function automatic logic [3:0] alu_code(input logic [2:0] f3, input logic is_op,
                                          input logic a);
    case (f3)
      3'b000:  alu_code = (is_op && a) ? 4'b0001 : 4'b0010;
      3'b001:  alu_code = 4'b0110;
      3'b010:  alu_code = 4'b1001;
      3'b011:  alu_code = 4'b1010;
      3'b100:  alu_code = 4'b0101;
      3'b101:  alu_code = a ? 4'b1000 : 4'b0111;
      3'b110:  alu_code = 4'b0100;
      default: alu_code = 4'b0011;
    endcase
  endfunction

  function automatic logic branch_taken(input logic [2:0] f3, input logic z,
                                        input logic l, input logic lu);
    case (f3)
      3'b000:  branch_taken = z;
      3'b001:  branch_taken = !z;
      3'b100:  branch_taken = l;
      3'b101:  branch_taken = !l;
      3'b110:  branch_taken = lu;
      3'b111:  branch_taken = !lu;
      default: branch_taken = 1'b0;
    endcase
  endfunction

  assign funct3    = ir[14:12];
  assign alt       = ir[30];
  assign cls       = classify(ir[6:0], funct3);
  assign unused_ir = ^{ir[31], ir[29:15], ir[11:7]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= FETCH;
      ir       <= '0;
      wait_cnt <= '0;
      retired  <= '0;
    end else begin
      state <= next_state;
      if (state == FETCH && instr_valid)
        ir <= instr;
      if (state != MEM)
        wait_cnt <= '0;
      else if (!mem_ready)
        wait_cnt <= wait_cnt + WAIT_W'(1);
      if (pc_en)
        retired <= retired + CNT_W'(1);
    end
  end

  always_comb begin
    next_state  = state;
    instr_ready = 1'b0;
    mem_req     = 1'b0;
    regRW       = 1'b0;
    ALUsrc      = 1'b0;
    MRW         = 1'b0;
    WB          = 1'b0;
    PCsrc       = 1'b0;
    pc_en       = 1'b0;
    immSel      = 2'b00;
    ALUop       = '0;
    illegal     = 1'b0;
    case (state)
      FETCH: begin
        // held low while reset is asserted even though the state already reads FETCH
        instr_ready = rst_n;
        if (instr_valid)
          next_state = DECODE;
      end
      DECODE: begin
        next_state = (cls == C_BAD) ? TRAP : EXEC;
      end
      EXEC: begin
        next_state = WBACK;
        case (cls)
          C_OPIMM: begin
            immSel = 2'b01;
            ALUop  = ALUOP_W'(alu_code(funct3, 1'b0, alt));
          end
          C_OP: begin
            ALUop = ALUOP_W'(alu_code(funct3, 1'b1, alt));
          end
          C_LOAD, C_STORE: begin
            ALUsrc     = 1'b1;
            immSel     = (cls == C_STORE) ? 2'b10 : 2'b01;
            next_state = MEM;
          end
          C_BRANCH: begin
            ALUop      = ALUOP_W'(4'b0001);
            immSel     = 2'b11;
            pc_en      = 1'b1;
            PCsrc      = branch_taken(funct3, zero, lt, ltu);
            next_state = FETCH;
          end
          C_JAL, C_JALR: begin
            ALUop  = ALUOP_W'(4'b0010);
            immSel = (cls == C_JAL) ? 2'b11 : 2'b01;
          end
          default: next_state = TRAP;
        endcase
      end
      MEM: begin
        mem_req = 1'b1;
        MRW     = (cls == C_STORE);
        if (mem_ready) begin
          if (cls == C_STORE) begin
            pc_en      = 1'b1;
            next_state = FETCH;
          end else begin
            next_state = WBACK;
          end
        end else if (wait_cnt == WAIT_W'(MEM_TIMEOUT - 1)) begin
          next_state = TRAP;
        end
      end
      WBACK: begin
        regRW      = 1'b1;
        WB         = (cls == C_LOAD);
        pc_en      = 1'b1;
        PCsrc      = (cls == C_JAL || cls == C_JALR);
        next_state = FETCH;
      end
      TRAP: begin
        illegal = 1'b1;
        if (trap_clr)
          next_state = FETCH;
      end
      default: next_state = FETCH;
    endcase
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: an instruction-level model expands each
// instruction into its expected per-cycle control trace, compared every cycle.
module tb_multicycle_control;
  localparam int ALUOP_W     = 4;
  localparam int MEM_TIMEOUT = 16;
  localparam int CNT_W       = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic [31:0] instr = '0;
  logic instr_valid = 1'b0, zero = 1'b0, lt = 1'b0, ltu = 1'b0;
  logic mem_ready = 1'b0, trap_clr = 1'b0;
  logic instr_ready, mem_req, regRW, ALUsrc, MRW, WB, PCsrc, pc_en, illegal;
  logic [1:0] immSel;
  logic [ALUOP_W-1:0] ALUop;
  logic [CNT_W-1:0] retired;

  multicycle_control #(.ALUOP_W(ALUOP_W), .MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .instr(instr), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .zero(zero), .lt(lt), .ltu(ltu), .mem_ready(mem_ready),
    .trap_clr(trap_clr), .mem_req(mem_req), .regRW(regRW), .ALUsrc(ALUsrc), .MRW(MRW),
    .WB(WB), .PCsrc(PCsrc), .pc_en(pc_en), .immSel(immSel), .ALUop(ALUop),
    .illegal(illegal), .retired(retired)
  );

  typedef struct packed {
    logic rdy, mreq, rw, asrc, mrw, wb, pcs, pce;
    logic [1:0] imm;
    logic [3:0] aop;
    logic ill;
  } ctl_t;

  ctl_t exp_c = '0;
  ctl_t act_c;
  bit   exp_on = 1'b0;
  int   model_ret = 0;
  int   checks = 0, errors = 0;

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (exp_on) begin
      act_c = {instr_ready, mem_req, regRW, ALUsrc, MRW, WB, PCsrc, pc_en, immSel,
               ALUop, illegal};
      checks++;
      if (act_c !== exp_c) begin
        errors++;
        $display("FAIL ctl t=%0t actual=%h required=%h", $time, act_c, exp_c);
      end
      checks++;
      if (retired !== CNT_W'(model_ret)) begin
        errors++;
        $display("FAIL retired t=%0t actual=%0d required=%0d", $time, retired,
                 CNT_W'(model_ret));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  // Instruction class: 0 OP-IMM, 1 OP, 2 LOAD, 3 STORE, 4 BRANCH, 5 JAL, 6 JALR, -1 trap
  function automatic int cls_of(input logic [31:0] w);
    logic [2:0] f3;
    f3 = w[14:12];
    case (w[6:0])
      7'b0010011: return 0;
      7'b0110011: return 1;
      7'b0000011: return 2;
      7'b0100011: return 3;
      7'b1100011: return (f3 == 3'd2 || f3 == 3'd3) ? -1 : 4;
      7'b1101111: return 5;
      7'b1100111: return 6;
      default:    return -1;
    endcase
  endfunction

  function automatic logic [3:0] alu_of(input logic [31:0] w, input int c);
    int tab[8] = '{2, 6, 9, 10, 5, 7, 4, 3};
    int f3, a;
    f3 = int'(w[14:12]);
    a  = tab[f3];
    if (f3 == 0 && c == 1 && w[30]) a = 1;
    if (f3 == 5 && w[30]) a = 8;
    return 4'(a);
  endfunction

  function automatic logic taken_of(input logic [31:0] w, input logic z, input logic l,
                                    input logic lu);
    int f3;
    f3 = int'(w[14:12]);
    if (f3 == 0) return z;
    if (f3 == 1) return !z;
    if (f3 == 4) return l;
    if (f3 == 5) return !l;
    if (f3 == 6) return lu;
    return !lu;
  endfunction

  function automatic logic [31:0] enc(input logic [6:0] op, input logic [2:0] f3,
                                      input logic b30);
    return {1'b0, b30, 5'd0, 5'd2, 5'd1, f3, 5'd3, op};
  endfunction

  task automatic cyc(input ctl_t e);
    exp_c  = e;
    exp_on = 1'b1;
    @(posedge clk);
    if (e.pce) model_ret++;
    #1;
  endtask

  task automatic idle();
    ctl_t e;
    e = '0;
    e.rdy = 1'b1;
    instr_valid = 1'b0;
    cyc(e);
  endtask

  task automatic trap_seq();
    ctl_t e;
    e = '0;
    e.ill = 1'b1;
    trap_clr = 1'b0;
    cyc(e);
    cyc(e);
    trap_clr = 1'b1;
    cyc(e);
    trap_clr = 1'b0;
  endtask

  // ready_at: MEM cycle (1-based) with mem_ready=1, 0 = never; abort_at: MEM cycle
  // in which reset is pulsed, 0 = none; lit_*: hand-computed EXEC values, -1 = skip.
  task automatic run_instr(input logic [31:0] ins, input int ready_at, input int abort_at,
                           input logic zf, input logic ltf, input logic ltuf,
                           input int lit_alu, input int lit_pcs);
    ctl_t e;
    int c, k;
    c = cls_of(ins);
    zero = zf; lt = ltf; ltu = ltuf;
    instr = ins; instr_valid = 1'b1;
    e = '0; e.rdy = 1'b1;
    cyc(e);
    instr_valid = 1'b0;
    instr = ~ins;
    e = '0;
    cyc(e);
    if (c < 0) begin
      trap_seq();
      return;
    end
    e = '0;
    case (c)
      0: begin e.aop = alu_of(ins, c); e.imm = 2'b01; end
      1: begin e.aop = alu_of(ins, c); e.imm = 2'b00; end
      2: begin e.asrc = 1'b1; e.imm = 2'b01; end
      3: begin e.asrc = 1'b1; e.imm = 2'b10; end
      4: begin e.aop = 4'd1; e.imm = 2'b11; e.pce = 1'b1; e.pcs = taken_of(ins, zf, ltf, ltuf); end
      5: begin e.aop = 4'd2; e.imm = 2'b11; end
      default: begin e.aop = 4'd2; e.imm = 2'b01; end
    endcase
    if (lit_alu >= 0 || lit_pcs >= 0) begin
      #2;
      if (lit_alu >= 0) chk("lit_exec_aluop", 32'(ALUop), lit_alu);
      if (lit_pcs >= 0) chk("lit_exec_pcsrc", 32'(PCsrc), lit_pcs);
    end
    cyc(e);
    if (c == 4) return;
    if (c == 2 || c == 3) begin
      for (k = 1; k <= MEM_TIMEOUT; k++) begin
        mem_ready = (k == ready_at);
        e = '0;
        e.mreq = 1'b1;
        e.mrw  = (c == 3);
        e.pce  = mem_ready && (c == 3);
        if (k == abort_at) begin
          exp_c = e; exp_on = 1'b1;
          #2;
          rst_n = 1'b0;
          model_ret = 0;
          exp_c = '0;
          #1;
          chk("abort_mem_req", 32'(mem_req), 0);
          chk("abort_retired", 32'(retired), 0);
          @(posedge clk);
          #1;
          rst_n = 1'b1;
          mem_ready = 1'b0;
          return;
        end
        cyc(e);
        if (mem_ready) break;
      end
      mem_ready = 1'b0;
      if (k > MEM_TIMEOUT) begin
        trap_seq();
        return;
      end
      if (c == 3) return;
    end
    e = '0;
    e.rw = 1'b1; e.wb = (c == 2); e.pce = 1'b1; e.pcs = (c == 5 || c == 6);
    cyc(e);
  endtask

  logic [31:0] wrap_tbl[16];
  logic [31:0] w;

  initial begin
    wrap_tbl = '{enc(7'b0110011, 3'd0, 1'b0), enc(7'b0110011, 3'd0, 1'b1),
                 enc(7'b0110011, 3'd7, 1'b0), enc(7'b0110011, 3'd4, 1'b0),
                 enc(7'b0110011, 3'd1, 1'b0), enc(7'b0110011, 3'd5, 1'b0),
                 enc(7'b0110011, 3'd5, 1'b1), enc(7'b0110011, 3'd2, 1'b0),
                 enc(7'b0110011, 3'd3, 1'b0), enc(7'b0010011, 3'd5, 1'b1),
                 enc(7'b0010011, 3'd0, 1'b1), enc(7'b1101111, 3'd0, 1'b0),
                 enc(7'b1100111, 3'd0, 1'b0), enc(7'b1100011, 3'd5, 1'b0),
                 enc(7'b0000011, 3'd2, 1'b0), enc(7'b0100011, 3'd2, 1'b0)};

    #1 rst_n = 1'b0;
    #2;
    chk("rst_instr_ready", 32'(instr_ready), 0);
    chk("rst_mem_req", 32'(mem_req), 0);
    chk("rst_illegal", 32'(illegal), 0);
    chk("rst_retired", 32'(retired), 0);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    chk("post_rst_instr_ready", 32'(instr_ready), 1);
    idle();

    run_instr(32'h00450693, 0, 0, 1'b0, 1'b0, 1'b0, 2, -1);
    chk("addi_retired", 32'(retired), 1);
    run_instr(32'h0006a803, 3, 0, 1'b0, 1'b0, 1'b0, -1, -1);
    chk("lw_retired", 32'(retired), 2);
    run_instr(32'h01162023, 0, 0, 1'b0, 1'b0, 1'b0, -1, -1);
    chk("sw_timeout_retired", 32'(retired), 2);
    run_instr(32'h00b76463, 0, 0, 1'b0, 1'b0, 1'b1, 1, 1);
    chk("bltu_taken_retired", 32'(retired), 3);
    run_instr(32'h00b76463, 0, 0, 1'b0, 1'b0, 1'b0, 1, 0);
    chk("bltu_not_taken_retired", 32'(retired), 4);
    run_instr(32'h00000000, 0, 0, 1'b0, 1'b0, 1'b0, -1, -1);
    run_instr(enc(7'b1100011, 3'd2, 1'b0), 0, 0, 1'b0, 1'b0, 1'b0, -1, -1);
    chk("traps_retired", 32'(retired), 4);
    run_instr(32'h01162023, MEM_TIMEOUT, 0, 1'b0, 1'b0, 1'b0, -1, -1);
    run_instr(32'h0006a803, 1, 0, 1'b0, 1'b0, 1'b0, -1, -1);
    idle();
    run_instr(enc(7'b0010011, 3'd6, 1'b0), 0, 0, 1'b0, 1'b0, 1'b0, 4, -1);
    run_instr(enc(7'b0110011, 3'd6, 1'b0), 0, 0, 1'b0, 1'b0, 1'b0, 4, -1);
    run_instr(enc(7'b1100011, 3'd0, 1'b0), 0, 0, 1'b1, 1'b0, 1'b0, -1, 1);
    run_instr(enc(7'b1100011, 3'd1, 1'b0), 0, 0, 1'b1, 1'b0, 1'b0, -1, 0);
    run_instr(enc(7'b1100011, 3'd4, 1'b0), 0, 0, 1'b0, 1'b1, 1'b0, -1, 1);
    run_instr(enc(7'b1100011, 3'd7, 1'b0), 0, 0, 1'b0, 1'b0, 1'b0, -1, 1);
    run_instr(enc(7'b1101111, 3'd0, 1'b0), 0, 0, 1'b0, 1'b0, 1'b0, 2, -1);
    chk("pre_abort_retired", 32'(retired), 13);

    run_instr(32'h0006a803, 0, 2, 1'b0, 1'b0, 1'b0, -1, -1);
    chk("after_abort_retired", 32'(retired), 0);
    idle();

    for (int i = 0; i < 16; i++) begin
      w = wrap_tbl[i];
      run_instr(w, (cls_of(w) == 2 || cls_of(w) == 3) ? 2 : 0, 0,
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), -1, -1);
    end
    chk("wrap_retired", 32'(retired), 0);
    idle();

    exp_on = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 The block SHALL have the following parameters, one per line: name, default, meaning.
- ALUOP_W, 4, ALUop width; values below zero-extend to this width; SHALL be 4 or more.
- MEM_TIMEOUT, 16, maximum wait cycles for mem_ready.
- CNT_W, 32, width of the retired-instruction counter.

REQ-002 The block SHALL have the following ports, one per line: name, direction, width, meaning.
- clk, in, 1, single clock; all state updates on the rising edge.
- rst_n, in, 1, reset, asynchronous and active-low.
- instr, in, 32, RV32I instruction word.
- instr_valid, in, 1, instr is valid.
- instr_ready, out, 1, block accepts instr this cycle.
- zero, in, 1, ALU result equals zero.
- lt, in, 1, signed rs1 < rs2.
- ltu, in, 1, unsigned rs1 < rs2.
- mem_ready, in, 1, data memory has completed the access.
- trap_clr, in, 1, leave TRAP.
- mem_req, out, 1, data memory access request.
- regRW, out, 1, register file write enable.
- ALUsrc, out, 1, ALU operands form a memory address.
- MRW, out, 1, memory write (1) or read (0).
- WB, out, 1, write-back source is memory.
- PCsrc, out, 1, PC takes the target (branch or jump) path.
- pc_en, out, 1, PC update strobe.
- immSel, out, 2, immediate format: 00 none, 01 I, 10 S, 11 B/J.
- ALUop, out, ALUOP_W, ALU operation.
- illegal, out, 1, trap flag.
- retired, out, CNT_W, count of completed instructions.

Function
REQ-003 The FSM SHALL have the states FETCH, DECODE, EXEC, MEM, WBACK and TRAP.
REQ-004 All outputs SHALL be decoded from the state register and the internal instruction register IR only, never from instr directly.
REQ-005 In FETCH, instr_ready SHALL be 1; when instr_valid=1, IR SHALL load instr and the FSM SHALL move to DECODE; otherwise it SHALL stay in FETCH.
REQ-006 DECODE SHALL take one cycle and classify IR[6:0] as follows:
- 0010011 OP-IMM, 0110011 OP, 0000011 LOAD, 0100011 STORE, 1100011 BRANCH, 1101111 JAL, 1100111 JALR lead to EXEC.
- Any other opcode SHALL lead to TRAP.
REQ-007 EXEC SHALL last one cycle and drive outputs per class:
- OP-IMM: immSel=01.
- OP: immSel=00.
- LOAD and STORE: ALUsrc=1, ALUop=0000, immSel=01 for LOAD and 10 for STORE.
- BRANCH: ALUop=0001, immSel=11.
- JAL and JALR: ALUop=0010, immSel=11 for JAL and 01 for JALR.
REQ-008 The ALU function for OP-IMM and OP SHALL map from funct3 as follows:
- 000 is ADD 0010; for OP with IR[30]=1 it is SUB 0001.
- 111 AND 0011, 110 OR 0100, 100 XOR 0101, 001 SLL 0110.
- 101 is SRL 0111, or SRA 1000 when IR[30]=1.
- 010 SLT 1001, 011 SLTU 1010.
REQ-009 BRANCH taken SHALL be evaluated by funct3 as follows, and any other funct3 SHALL go to TRAP:
- BEQ taken if zero; BNE if !zero.
- BLT if lt; BGE if !lt.
- BLTU if ltu; BGEU if !ltu.
REQ-010 Next-state from EXEC SHALL be:
- BRANCH: pc_en=1 and PCsrc=taken in the same cycle, then FETCH.
- LOAD and STORE: MEM.
- All other classes: WBACK.
REQ-011 In MEM, mem_req SHALL be 1 and MRW SHALL be 1 for STORE and 0 for LOAD. A wait counter SHALL clear on MEM entry and increment each cycle mem_ready=0.
REQ-012 Exits from MEM SHALL be:
- mem_ready=1 with LOAD: WBACK.
- mem_ready=1 with STORE: pc_en=1 in that cycle, then FETCH.
- Wait counter reaching MEM_TIMEOUT without mem_ready: TRAP.
- mem_ready=1 in the same cycle the counter reaches MEM_TIMEOUT: the access completes normally (mem_ready wins).
REQ-013 WBACK SHALL last one cycle with regRW=1, WB=1 only for LOAD, and pc_en=1. PCsrc=1 for JAL and JALR. The FSM then moves to FETCH.
REQ-014 retired SHALL increment by 1 on every pc_en pulse and SHALL wrap modulo 2^CNT_W.
REQ-015 TRAP SHALL hold illegal=1 with all other control outputs 0. trap_clr=1 SHALL move the FSM to FETCH in the next cycle. retired SHALL NOT count trapped instructions.
REQ-016 At most one pc_en pulse SHALL occur per accepted instruction.
REQ-017 In all states except those where this specification sets a control output, that output SHALL be 0.

Reset
REQ-018 When rst_n=0, the block SHALL immediately, regardless of clk, set state=FETCH, and clear IR, the wait counter and retired to 0.
REQ-019 While in reset, all outputs SHALL be 0 except instr_ready, which SHALL be 1 once rst_n=1.
REQ-020 Reset asserted mid-MEM SHALL abort the access: mem_req SHALL drop asynchronously, and no regRW or pc_en SHALL follow.

Verification
REQ-021 A bench SHALL cover the following directed scenarios:
- instr=0x00450693 (addi) with instr_valid=1 -> DECODE, EXEC with ALUop=0010 and immSel=01, then WBACK with regRW=1 and pc_en=1; retired=1 after 4 cycles.
- instr=0x0006a803 (lw) with mem_ready asserted on the 3rd MEM cycle -> mem_req=1 and MRW=0 for 3 cycles, then WBACK with WB=1 and regRW=1; retired increments by 1.
- instr=0x01162023 (sw) with mem_ready held 0 -> TRAP after MEM_TIMEOUT=16 cycles with illegal=1; trap_clr=1 -> FETCH; retired is unchanged.
- instr=0x00b76463 (bltu) with ltu=1 -> EXEC with pc_en=1 and PCsrc=1; repeat with ltu=0 -> PCsrc=0; the instruction is never in WBACK.
- instr=0x00000000 -> TRAP from DECODE with illegal=1; rst_n=0 mid-MEM of lw -> mem_req=0 and retired=0 immediately.
- retired preset via CNT_W=4 and 16 instructions -> retired wraps to 0.
